// File: rtl/code_sequencer_if.sv
// Handshake bundle between the code sequencer and whoever drives it.
// The master drives the controls and the slave (the sequencer) returns the codeword and its status.
interface code_sequencer_if;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_idx;
  logic [3:0] code_out;
  logic [3:0] idx_out;
  logic       code_valid;
  logic       wrap;
  logic       load_err;

  modport master (
    output en, up, load, load_idx,
    input  code_out, idx_out, code_valid, wrap, load_err
  );

  modport slave (
    input  en, up, load, load_idx,
    output code_out, idx_out, code_valid, wrap, load_err
  );
endinterface

// File: rtl/code_sequencer.sv
// Walks the ten legal converter codewords, stepping up or down at a programmable rate.
// All outputs are registered; the codeword is decoded from the next index so it always tracks idx_out.
module code_sequencer #(
  parameter int TICK_DIV = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  code_sequencer_if.slave         bus
);

  localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t     state, nxt_state;
  logic [3:0] idx, nxt_idx;
  logic [7:0] pcnt, nxt_pcnt;
  logic [3:0] code_q;
  logic       valid_q, wrap_q, err_q;
  logic       nxt_wrap, nxt_err, do_count;

  function automatic logic [3:0] code_of(input logic [3:0] i);
    case (i)
      4'd0:    code_of = 4'b0000;
      4'd1:    code_of = 4'b0001;
      4'd2:    code_of = 4'b0011;
      4'd3:    code_of = 4'b0100;
      4'd4:    code_of = 4'b0101;
      4'd5:    code_of = 4'b0111;
      4'd6:    code_of = 4'b1001;
      4'd7:    code_of = 4'b1011;
      4'd8:    code_of = 4'b1100;
      4'd9:    code_of = 4'b1101;
      default: code_of = 4'b0000;
    endcase
  endfunction

  // A load cycle does nothing but the load, so a step that was due is dropped.
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_pcnt  = pcnt;
    nxt_wrap  = 1'b0;
    nxt_err   = 1'b0;
    do_count  = 1'b0;
    if (bus.load) begin
      if (bus.load_idx <= 4'd9) begin
        nxt_idx  = bus.load_idx;
        nxt_pcnt = 8'd0;
        if (state == IDLE) nxt_state = PAUSE;
      end else begin
        nxt_err = 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.en) begin
            nxt_state = RUN;
            nxt_pcnt  = 8'd0;
          end
        end
        RUN: begin
          if (bus.en) do_count  = 1'b1;
          else        nxt_state = PAUSE;
        end
        PAUSE: begin
          // Resuming counts immediately, so the held prescaler phase is preserved.
          if (bus.en) begin
            nxt_state = RUN;
            do_count  = 1'b1;
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
    if (do_count) begin
      if (pcnt == TICK_LAST) begin
        nxt_pcnt = 8'd0;
        if (bus.up) begin
          if (idx == 4'd9) begin
            nxt_idx  = 4'd0;
            nxt_wrap = 1'b1;
          end else begin
            nxt_idx = idx + 4'd1;
          end
        end else begin
          if (idx == 4'd0) begin
            nxt_idx  = 4'd9;
            nxt_wrap = 1'b1;
          end else begin
            nxt_idx = idx - 4'd1;
          end
        end
      end else begin
        nxt_pcnt = pcnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= 4'd0;
      pcnt    <= 8'd0;
      code_q  <= 4'b0000;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= nxt_state;
      idx     <= nxt_idx;
      pcnt    <= nxt_pcnt;
      code_q  <= code_of(nxt_idx);
      valid_q <= (nxt_state != IDLE);
      wrap_q  <= nxt_wrap;
      err_q   <= nxt_err;
    end
  end

  assign bus.code_out   = code_q;
  assign bus.idx_out    = idx;
  assign bus.code_valid = valid_q;
  assign bus.wrap       = wrap_q;
  assign bus.load_err   = err_q;

endmodule
